// File: rtl/eight_bit_divider.sv
// eight_bit_divider: sequential unsigned restoring divider, one trial subtraction per clock,
// with a start/busy/done handshake and an immediate divide-by-zero result.
module eight_bit_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);
  localparam int NW = $clog2(WIDTH + 1);
  typedef enum logic {IDLE, RUN} state_t;
  state_t           r_state;
  logic [WIDTH-1:0] r_d;
  logic [WIDTH-1:0] r_v;
  logic [WIDTH-1:0] r_r;
  logic [NW-1:0]    r_n;
  logic [WIDTH:0]   w_rs;
  logic [WIDTH:0]   w_t;
  logic             w_qb;
  logic [WIDTH-1:0] w_rn;
  logic [WIDTH-1:0] w_dn;
  // The partial remainder stays below the divisor, so only the shifted trial value needs the extra bit.
  assign w_rs = {r_r, r_d[WIDTH-1]};
  assign w_t  = w_rs - {1'b0, r_v};
  assign w_qb = ~w_t[WIDTH];
  assign w_rn = w_qb ? w_t[WIDTH-1:0] : w_rs[WIDTH-1:0];
  assign w_dn = {r_d[WIDTH-2:0], w_qb};
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_d         <= '0;
      r_v         <= '0;
      r_r         <= '0;
      r_n         <= '0;
      Quotient    <= '0;
      Remainder   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      if (r_state == IDLE) begin
        if (start && B == '0) begin
          Quotient    <= '1;
          Remainder   <= A;
          div_by_zero <= 1'b1;
          done        <= 1'b1;
        end else if (start) begin
          r_d         <= A;
          r_v         <= B;
          r_r         <= '0;
          r_n         <= '0;
          div_by_zero <= 1'b0;
          busy        <= 1'b1;
          r_state     <= RUN;
        end
      end else begin
        r_r <= w_rn;
        r_d <= w_dn;
        r_n <= r_n + 1'b1;
        if (r_n == NW'(WIDTH - 1)) begin
          Quotient  <= w_dn;
          Remainder <= w_rn;
          done      <= 1'b1;
          busy      <= 1'b0;
          r_state   <= IDLE;
        end
      end
    end
  end
endmodule

// File: tb/tb_eight_bit_divider.sv
// tb_eight_bit_divider: directed checks of the restoring divider handshake, results and reset abort.
module tb_eight_bit_divider;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] A = '0;
  logic [7:0] B = '0;
  logic [7:0] Quotient;
  logic [7:0] Remainder;
  logic       busy;
  logic       done;
  logic       div_by_zero;
  int         checks = 0;
  int         errors = 0;
  int         done_cnt = 0;

  eight_bit_divider #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B),
    .Quotient(Quotient), .Remainder(Remainder), .busy(busy), .done(done),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

  // Pulses start for one cycle and waits for done; lat counts edges after the accepting edge, -1 on timeout.
  task automatic run_div(input logic [7:0] a, input logic [7:0] b, output int lat);
    @(negedge clk);
    A = a; B = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (done !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (done !== 1'b1) lat = -1;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    checks++; if (Quotient !== 8'd0) begin errors++; $display("FAIL reset_q got %0d expected 0", Quotient); end
    checks++; if (Remainder !== 8'd0) begin errors++; $display("FAIL reset_r got %0d expected 0", Remainder); end
    checks++; if ({busy, done, div_by_zero} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b expected 000", {busy, done, div_by_zero}); end
    A = 8'd10; B = 8'd2; start = 1'b1;
    @(negedge clk);
    checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL reset_wins got %b expected 00", {busy, done}); end
    rst = 1'b0; start = 1'b0;
  endtask

  task automatic test_basic;
    @(negedge clk);
    A = 8'd200; B = 8'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks++; if ({busy, done} !== 2'b10) begin errors++; $display("FAIL basic_busy[%0d] got %b expected 10", i, {busy, done}); end
      @(negedge clk);
    end
    checks++; if ({busy, done} !== 2'b01) begin errors++; $display("FAIL basic_done got %b expected 01", {busy, done}); end
    checks++; if (Quotient !== 8'd28) begin errors++; $display("FAIL basic_q got %0d expected 28", Quotient); end
    checks++; if (Remainder !== 8'd4) begin errors++; $display("FAIL basic_r got %0d expected 4", Remainder); end
    checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL basic_dbz got %b expected 0", div_by_zero); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_pulse got %b expected 0", done); end
  endtask

  task automatic test_boundaries;
    logic [7:0] va [4] = '{8'd255, 8'd5, 8'd0, 8'd255};
    logic [7:0] vb [4] = '{8'd1, 8'd9, 8'd3, 8'd255};
    logic [7:0] vq [4] = '{8'd255, 8'd0, 8'd0, 8'd1};
    logic [7:0] vr [4] = '{8'd0, 8'd5, 8'd0, 8'd0};
    int lat;
    for (int i = 0; i < 4; i++) begin
      run_div(va[i], vb[i], lat);
      checks++; if (lat != 8) begin errors++; $display("FAIL bound_lat[%0d] got %0d expected 8", i, lat); end
      checks++; if (Quotient !== vq[i]) begin errors++; $display("FAIL bound_q[%0d] got %0d expected %0d", i, Quotient, vq[i]); end
      checks++; if (Remainder !== vr[i]) begin errors++; $display("FAIL bound_r[%0d] got %0d expected %0d", i, Remainder, vr[i]); end
    end
  endtask

  task automatic test_div_zero;
    int lat;
    run_div(8'd37, 8'd0, lat);
    checks++; if (lat != 0) begin errors++; $display("FAIL dz_lat got %0d expected 0", lat); end
    checks++; if (Quotient !== 8'hFF) begin errors++; $display("FAIL dz_q got %0d expected 255", Quotient); end
    checks++; if (Remainder !== 8'd37) begin errors++; $display("FAIL dz_r got %0d expected 37", Remainder); end
    checks++; if ({busy, div_by_zero} !== 2'b01) begin errors++; $display("FAIL dz_flags got %b expected 01", {busy, div_by_zero}); end
    @(negedge clk);
    checks++; if ({done, div_by_zero} !== 2'b01) begin errors++; $display("FAIL dz_hold got %b expected 01", {done, div_by_zero}); end
    run_div(8'd20, 8'd4, lat);
    checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL dz_clear got %b expected 0", div_by_zero); end
    checks++; if (Quotient !== 8'd5 || Remainder !== 8'd0) begin errors++; $display("FAIL dz_next got q=%0d r=%0d expected q=5 r=0", Quotient, Remainder); end
  endtask

  task automatic test_back_to_back;
    int n;
    @(negedge clk);
    A = 8'd100; B = 8'd10; start = 1'b1;
    @(negedge clk);
    A = 8'd99;
    n = 0;
    while (done !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_first_done got %b expected 1", done); end
    checks++; if (Quotient !== 8'd10 || Remainder !== 8'd0) begin errors++; $display("FAIL b2b_first got q=%0d r=%0d expected q=10 r=0", Quotient, Remainder); end
    @(negedge clk);
    checks++; if ({busy, done} !== 2'b10) begin errors++; $display("FAIL b2b_accept got %b expected 10", {busy, done}); end
    checks++; if (Quotient !== 8'd10) begin errors++; $display("FAIL b2b_hold_q got %0d expected 10", Quotient); end
    n = 1;
    while (done !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    start = 1'b0;
    checks++; if (n != 9) begin errors++; $display("FAIL b2b_period got %0d expected 9", n); end
    checks++; if (Quotient !== 8'd9 || Remainder !== 8'd9) begin errors++; $display("FAIL b2b_second got q=%0d r=%0d expected q=9 r=9", Quotient, Remainder); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle got %b expected 0", busy); end
  endtask

  task automatic test_reset_mid;
    int snap;
    int lat;
    @(negedge clk);
    snap = done_cnt;
    A = 8'd170; B = 8'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (Quotient !== 8'd0 || Remainder !== 8'd0) begin errors++; $display("FAIL abort_qr got q=%0d r=%0d expected 0 0", Quotient, Remainder); end
    checks++; if ({busy, done, div_by_zero} !== 3'b000) begin errors++; $display("FAIL abort_flags got %b expected 000", {busy, done, div_by_zero}); end
    repeat (12) @(negedge clk);
    checks++; if (done_cnt != snap) begin errors++; $display("FAIL abort_no_done got %0d expected %0d", done_cnt - snap, 0); end
    run_div(8'd170, 8'd3, lat);
    checks++; if (Quotient !== 8'd56 || Remainder !== 8'd2) begin errors++; $display("FAIL abort_fresh got q=%0d r=%0d expected q=56 r=2", Quotient, Remainder); end
  endtask

  task automatic test_sweep;
    int snap;
    int ops;
    int lat;
    int bad;
    @(negedge clk);
    snap = done_cnt;
    ops = 0;
    bad = 0;
    for (int a = 0; a < 256; a += 15) begin
      for (int b = 1; b < 256; b += 9) begin
        run_div(8'(a), 8'(b), lat);
        ops++;
        checks++;
        if (lat != 8 || Quotient !== 8'(a / b) || Remainder !== 8'(a % b) ||
            int'(Quotient) * b + int'(Remainder) != a || int'(Remainder) >= b) begin
          errors++;
          bad++;
          if (bad < 10) $display("FAIL sweep a=%0d b=%0d got q=%0d r=%0d lat=%0d expected q=%0d r=%0d lat=8", a, b, Quotient, Remainder, lat, a / b, a % b);
        end
      end
    end
    repeat (2) @(negedge clk);
    checks++; if (done_cnt - snap != ops) begin errors++; $display("FAIL sweep_done_count got %0d expected %0d", done_cnt - snap, ops); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_boundaries;
    test_div_zero;
    test_back_to_back;
    test_reset_mid;
    test_sweep;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
